// File: rtl/wic_multi.sv
// Multi-channel wake-up interrupt controller: per-channel trigger/enable/pending plus
// a req/ack handshake to the power controller. Optional macro WIC_INPUT_SYNC_EN adds a 2-flop int_vld synchroniser.
module wic_multi_ch (
  input  logic wic_clk,
  input  logic pad_cpu_rst_b,
  input  logic vld,
  input  logic cfg,
  input  logic int_exit,
  input  logic sel,
  input  logic awake_enable,
  input  logic awake_disable,
  input  logic clr,
  output logic pending,
  output logic awake_en
);
  logic vld_ff;

  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      vld_ff   <= 1'b0;
      pending  <= 1'b0;
      awake_en <= 1'b0;
    end else begin
      vld_ff <= vld;
      if (awake_enable && sel)       awake_en <= 1'b1;
      else if (awake_disable && sel) awake_en <= 1'b0;
      // Pulse mode: set beats clear so an edge landing with a clear is never dropped.
      if (!cfg)                pending <= vld && int_exit;
      else if (vld && !vld_ff) pending <= 1'b1;
      else if (clr)            pending <= 1'b0;
    end
  end
endmodule

module wic_multi #(
  parameter int INT_NUM = 32,
  parameter int ID_W    = 5
) (
  input  logic               wic_clk,
  input  logic               pad_cpu_rst_b,
  input  logic [INT_NUM-1:0] int_vld,
  input  logic [INT_NUM-1:0] int_cfg,
  input  logic               int_exit,
  input  logic [INT_NUM-1:0] awake_data,
  input  logic               awake_enable,
  input  logic               awake_disable,
  input  logic [INT_NUM-1:0] pending_clr,
  input  logic               wakeup_ack,
  output logic [INT_NUM-1:0] int_pending,
  output logic [INT_NUM-1:0] wic_awake_en,
  output logic               wakeup_req,
  output logic [ID_W-1:0]    wakeup_id
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state;
  logic [INT_NUM-1:0] vld_use;
  logic [INT_NUM-1:0] wake_vec;
  logic [ID_W-1:0]    lo_id;

`ifdef WIC_INPUT_SYNC_EN
  logic [INT_NUM-1:0] vld_s1, vld_s2;
  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      vld_s1 <= '0;
      vld_s2 <= '0;
    end else begin
      vld_s1 <= int_vld;
      vld_s2 <= vld_s1;
    end
  end
  assign vld_use = vld_s2;
`else
  assign vld_use = int_vld;
`endif

  for (genvar g = 0; g < INT_NUM; g++) begin : g_ch
    wic_multi_ch u_ch (
      .wic_clk       (wic_clk),
      .pad_cpu_rst_b (pad_cpu_rst_b),
      .vld           (vld_use[g]),
      .cfg           (int_cfg[g]),
      .int_exit      (int_exit),
      .sel           (awake_data[g]),
      .awake_enable  (awake_enable),
      .awake_disable (awake_disable),
      .clr           (pending_clr[g]),
      .pending       (int_pending[g]),
      .awake_en      (wic_awake_en[g])
    );
  end

  assign wake_vec = int_pending & wic_awake_en;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    lo_id = '0;
    for (int i = INT_NUM - 1; i >= 0; i--)
      if (wake_vec[i]) lo_id = ID_W'(i);
  end

  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state      <= S_IDLE;
      wakeup_req <= 1'b0;
      wakeup_id  <= '0;
    end else begin
      case (state)
        S_IDLE: if (|wake_vec) begin
          wakeup_id  <= lo_id;
          wakeup_req <= 1'b1;
          state      <= S_REQ;
        end
        S_REQ: if (wakeup_ack) begin
          wakeup_req <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: if (!wakeup_ack) state <= S_IDLE;
        default: begin
          wakeup_req <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wic_multi.sv
// Directed + randomized bench for wic_multi with a cycle-level behavioural reference model.
module tb_wic_multi;
  localparam int N  = 32;
  localparam int IW = 5;

  logic          wic_clk = 1'b0;
  logic          pad_cpu_rst_b;
  logic [N-1:0]  int_vld, int_cfg, awake_data, pending_clr;
  logic          int_exit, awake_enable, awake_disable, wakeup_ack;
  logic [N-1:0]  int_pending, wic_awake_en;
  logic          wakeup_req;
  logic [IW-1:0] wakeup_id;

  int checks = 0;
  int errors = 0;

  // reference state
  bit [N-1:0] m_pend, m_en, m_last;
`ifdef WIC_INPUT_SYNC_EN
  bit [N-1:0] m_s1, m_s2;
`endif
  int m_phase;   // 0 idle, 1 requesting, 2 awaiting ack release
  int m_id;

  wic_multi #(.INT_NUM(N), .ID_W(IW)) dut (
    .wic_clk(wic_clk), .pad_cpu_rst_b(pad_cpu_rst_b), .int_vld(int_vld), .int_cfg(int_cfg),
    .int_exit(int_exit), .awake_data(awake_data), .awake_enable(awake_enable),
    .awake_disable(awake_disable), .pending_clr(pending_clr), .wakeup_ack(wakeup_ack),
    .int_pending(int_pending), .wic_awake_en(wic_awake_en), .wakeup_req(wakeup_req),
    .wakeup_id(wakeup_id)
  );

  always #5 wic_clk = ~wic_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_last = '0; m_phase = 0; m_id = 0;
`ifdef WIC_INPUT_SYNC_EN
    m_s1 = '0; m_s2 = '0;
`endif
  endtask

  // One clock of the reference, from the inputs present at the edge.
  task automatic model_clock();
    bit [N-1:0] v, n_pend, n_en, wake;
    int lowest;
`ifdef WIC_INPUT_SYNC_EN
    v = m_s2; m_s2 = m_s1; m_s1 = int_vld;
`else
    v = int_vld;
`endif
    wake = m_pend & m_en;
    lowest = -1;
    for (int i = 0; i < N; i++) begin
      if (wake[i] && lowest < 0) lowest = i;
      if (awake_data[i] && awake_enable)       n_en[i] = 1'b1;
      else if (awake_data[i] && awake_disable) n_en[i] = 1'b0;
      else                                     n_en[i] = m_en[i];
      if (!int_cfg[i])               n_pend[i] = v[i] & int_exit;
      else if (v[i] && !m_last[i])   n_pend[i] = 1'b1;
      else if (pending_clr[i])       n_pend[i] = 1'b0;
      else                           n_pend[i] = m_pend[i];
    end
    if (m_phase == 0 && lowest >= 0) begin m_phase = 1; m_id = lowest; end
    else if (m_phase == 1 && wakeup_ack) m_phase = 2;
    else if (m_phase == 2 && !wakeup_ack) m_phase = 0;
    m_last = v; m_pend = n_pend; m_en = n_en;
  endtask

  task automatic step(input string tag);
    @(posedge wic_clk);
    model_clock();
    #1;
    check({tag, ".pending"}, 64'(int_pending), 64'(m_pend));
    check({tag, ".awake_en"}, 64'(wic_awake_en), 64'(m_en));
    check({tag, ".req"}, 64'(wakeup_req), 64'(m_phase == 1));
    check({tag, ".id"}, 64'(wakeup_id), 64'(m_id));
  endtask

  task automatic idle_cmds();
    awake_enable = 0; awake_disable = 0; awake_data = '0; pending_clr = '0;
  endtask

  initial begin
    pad_cpu_rst_b = 0; int_vld = '0; int_cfg = '0; int_exit = 1; wakeup_ack = 0;
    idle_cmds();
    model_reset();
    #2;
    check("rst.pending", 64'(int_pending), 64'(0));
    check("rst.awake_en", 64'(wic_awake_en), 64'(0));
    check("rst.req", 64'(wakeup_req), 64'(0));
    check("rst.id", 64'(wakeup_id), 64'(0));
    #10 pad_cpu_rst_b = 1;

    // Level mode, all lines high, nothing enabled
    int_vld = '1;
    step("lvl_all");
`ifndef WIC_INPUT_SYNC_EN
    check("lvl_all.const", 64'(int_pending), 64'(32'hFFFF_FFFF));
`endif
    step("lvl_all2");
    check("lvl_all.noreq", 64'(wakeup_req), 64'(0));

    // Enable wins over a simultaneous disable
    int_vld = '0;
    awake_enable = 1; awake_disable = 1; awake_data = 32'h5;
    step("en_win");
    check("en_win.const", 64'(wic_awake_en), 64'(32'h5));
    awake_enable = 0; awake_data = 32'h1;
    step("dis");
    check("dis.const", 64'(wic_awake_en), 64'(32'h4));
    idle_cmds();
    int_cfg = 32'h0000_009C;
    step("cfg");
    step("settle");

`ifndef WIC_INPUT_SYNC_EN
    // Ch2 pulse: pending at +1, request at +2, stable while unacked
    int_vld[2] = 1;
    step("p2.c1");
    check("p2.pend_const", 64'(int_pending[2]), 64'(1));
    step("p2.c2");
    check("p2.req_const", 64'(wakeup_req), 64'(1));
    check("p2.id_const", 64'(wakeup_id), 64'(2));
    for (int k = 0; k < 5; k++) step("p2.hold");
    check("p2.hold_req", 64'(wakeup_req), 64'(1));
    wakeup_ack = 1; pending_clr[2] = 1;
    step("p2.ack");
    wakeup_ack = 0; pending_clr = '0;
    step("p2.rel");

    // Pulse and clear together keep pending; clear alone drops it
    int_vld[3] = 1; pending_clr[3] = 1;
    step("p3.both");
    check("p3.both_const", 64'(int_pending[3]), 64'(1));
    step("p3.clr");
    check("p3.clr_const", 64'(int_pending[3]), 64'(0));
    pending_clr = '0;

    // Priority 4 over 7, re-request, then 7 after clearing 4
    awake_enable = 1; awake_data = 32'h90;
    step("p47.en");
    idle_cmds();
    int_vld[4] = 1; int_vld[7] = 1;
    step("p47.pend");
    step("p47.req");
    check("p47.id4", 64'(wakeup_id), 64'(4));
    wakeup_ack = 1; step("p47.ack");
    wakeup_ack = 0; step("p47.rel");
    check("p47.idle", 64'(wakeup_req), 64'(0));
    step("p47.req2");
    check("p47.id4b", 64'(wakeup_id), 64'(4));
    wakeup_ack = 1; pending_clr[4] = 1; step("p47.ack2");
    wakeup_ack = 0; pending_clr = '0; step("p47.rel2");
    step("p47.req3");
    check("p47.id7", 64'(wakeup_id), 64'(7));
    check("p47.req7", 64'(wakeup_req), 64'(1));
    wakeup_ack = 1; step("p47.wait");
`endif

    // Async reset while waiting on ack release
    @(negedge wic_clk);
    pad_cpu_rst_b = 0;
    #1;
    model_reset();
    check("arst.pending", 64'(int_pending), 64'(0));
    check("arst.awake_en", 64'(wic_awake_en), 64'(0));
    check("arst.req", 64'(wakeup_req), 64'(0));
    check("arst.id", 64'(wakeup_id), 64'(0));
    int_vld = '0; wakeup_ack = 0; idle_cmds();
    @(negedge wic_clk);
    pad_cpu_rst_b = 1;
    step("post_rst");
    step("post_rst2");

    // Randomized traffic against the reference
    for (int k = 0; k < 400; k++) begin
      int_vld       = $urandom;
      if ($urandom_range(0, 15) == 0) int_cfg = $urandom;
      int_exit      = ($urandom_range(0, 3) != 0);
      awake_data    = $urandom;
      awake_enable  = ($urandom_range(0, 3) == 0);
      awake_disable = ($urandom_range(0, 3) == 0);
      pending_clr   = $urandom & $urandom;
      wakeup_ack    = $urandom_range(0, 1);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
